// File: rtl/mac_pkg.sv
// mac_pkg: shared width helpers and the saturating accumulate step for the
// N-lane dot-product accumulator.
//   prod_w(w)    : width of one signed lane product (2w+1)
//   sum_w(w, n)  : width of the adder-tree result over n products
//   sat_add(...) : one accumulate step in acc_w+1 bits with overflow detect
//                  and optional clamp; result carried in a 64-bit container
package mac_pkg;

    // Widest accumulator sat_add can evaluate (needs one spare bit in 64).
    localparam int MAX_ACC_W = 63;

    typedef struct packed {
        logic        ovf;
        logic [63:0] value;
    } sat_res_t;

    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w, input int n);
        return prod_w(w) + $clog2(n);
    endfunction

    // base and addend arrive sign-extended from acc_w bits. The sum is formed
    // one bit wider than needed so the range test is exact. On wrap the low
    // acc_w bits of value are the wrapped result; the caller truncates.
    function automatic sat_res_t sat_add(input logic signed [63:0] base,
                                         input logic signed [63:0] addend,
                                         input logic               sat,
                                         input int                 acc_w);
        logic signed [64:0] nxt;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sat_res_t           res;
        nxt   = 65'(base) + 65'(addend);
        max_v = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (acc_w - 1));
        res.ovf = (nxt > max_v) || (nxt < min_v);
        if (res.ovf && sat) begin
            if (nxt > max_v) begin
                res.value = max_v[63:0];
            end else begin
                res.value = min_v[63:0];
            end
        end else begin
            res.value = nxt[63:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_tree_n.sv
// adder_tree_n: combinational balanced adder tree over N signed IN_W-bit
// values. Each level sign-extends its two halves by one bit before adding, so
// the result never overflows.
//   lanes_s : N packed signed inputs, lane k = lanes_s[k*IN_W +: IN_W]
//   sum_s   : signed sum, IN_W + $clog2(N) bits (a plain wire when N = 1)
module adder_tree_n #(
    parameter int N    = 8,
    parameter int IN_W = 17
) (
    input  logic [N*IN_W-1:0]           lanes_s,
    output logic [IN_W+$clog2(N)-1:0]   sum_s
);

    localparam int OUT_W = IN_W + $clog2(N);

    generate
        if (N == 1) begin : g_leaf
            assign sum_s = lanes_s;
        end else begin : g_split
            // Lower half gets floor(N/2) lanes; odd counts put the extra lane high.
            localparam int NL = N / 2;
            localparam int NH = N - NL;
            localparam int LW = IN_W + $clog2(NL);
            localparam int HW = IN_W + $clog2(NH);

            logic [LW-1:0] lo_s;
            logic [HW-1:0] hi_s;

            adder_tree_n #(.N(NL), .IN_W(IN_W)) u_lo (
                .lanes_s (lanes_s[NL*IN_W-1:0]),
                .sum_s   (lo_s)
            );

            adder_tree_n #(.N(NH), .IN_W(IN_W)) u_hi (
                .lanes_s (lanes_s[N*IN_W-1:NL*IN_W]),
                .sum_s   (hi_s)
            );

            assign sum_s = OUT_W'($signed(lo_s)) + OUT_W'($signed(hi_s));
        end
    endgenerate

endmodule

// File: rtl/mac_dot_accum.sv
// mac_dot_accum: N-lane W-bit dot product per beat, accumulated over the
// beats of a vector into a signed ACC_W result emitted on the last beat.
// Three stages (P: products, S: tree sum, A: accumulate), all advancing on a
// single enable, so downstream backpressure freezes the whole pipeline.
//   i_clk, i_rst        : clock, async active-high reset
//   i_valid / o_ready   : input beat handshake
//   i_a, i_b            : packed lane operands, lane k = [k*W +: W]
//   i_signed, i_sat     : per-beat operand signedness / saturating accumulate
//   i_last              : last beat of the current vector
//   o_valid / i_ready   : result handshake
//   o_res, o_ovf        : accumulated result, sticky overflow for the vector
module mac_dot_accum
    import mac_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int ACC_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N*W-1:0]     i_a,
    input  logic [N*W-1:0]     i_b,
    input  logic               i_signed,
    input  logic               i_sat,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W-1:0]   o_res,
    output logic               o_ovf
);

    localparam int PROD_W = prod_w(W);
    localparam int SUM_W  = sum_w(W, N);

    generate
        if (ACC_W < SUM_W) begin : g_bad_acc_w
            $error("mac_dot_accum: ACC_W too narrow for N lanes of W-bit products");
        end
        if (ACC_W > MAX_ACC_W) begin : g_big_acc_w
            $error("mac_dot_accum: ACC_W exceeds the 63-bit accumulate helper");
        end
    endgenerate

    logic                en_s;
    logic [N*PROD_W-1:0] prod_s;
    logic [N*PROD_W-1:0] prod_r;
    logic                valid_p_r;
    logic                last_p_r;
    logic                sat_p_r;
    logic [SUM_W-1:0]    tree_sum_s;
    logic [SUM_W-1:0]    sum_r;
    logic                valid_s_r;
    logic                last_s_r;
    logic                sat_s_r;
    logic [ACC_W-1:0]    acc_r;
    logic                first_r;
    logic                ovf_acc_r;
    logic [ACC_W-1:0]    base_s;
    logic [ACC_W-1:0]    sum_ext_s;
    sat_res_t            step_s;
    logic [ACC_W-1:0]    value_s;
    logic                ovf_step_s;
    logic                unused_hi_s;

    // A held result blocks every stage; otherwise everything advances.
    assign en_s    = !o_valid || i_ready;
    assign o_ready = en_s;

    // Lane products: operands widened by one bit (sign or zero) then multiplied.
    always_comb begin
        logic signed [W:0] a_ext;
        logic signed [W:0] b_ext;
        prod_s = '0;
        for (int k = 0; k < N; k++) begin
            a_ext = {i_signed & i_a[k*W+W-1], i_a[k*W +: W]};
            b_ext = {i_signed & i_b[k*W+W-1], i_b[k*W +: W]};
            prod_s[k*PROD_W +: PROD_W] = PROD_W'(a_ext) * PROD_W'(b_ext);
        end
    end

    // Stage P register: products plus the beat's control bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prod_r    <= '0;
            valid_p_r <= 1'b0;
            last_p_r  <= 1'b0;
            sat_p_r   <= 1'b0;
        end else if (en_s) begin
            prod_r    <= prod_s;
            valid_p_r <= i_valid;
            last_p_r  <= i_last;
            sat_p_r   <= i_sat;
        end
    end

    adder_tree_n #(.N(N), .IN_W(PROD_W)) u_tree (
        .lanes_s (prod_r),
        .sum_s   (tree_sum_s)
    );

    // Stage S register: reduced beat sum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_r     <= '0;
            valid_s_r <= 1'b0;
            last_s_r  <= 1'b0;
            sat_s_r   <= 1'b0;
        end else if (en_s) begin
            sum_r     <= tree_sum_s;
            valid_s_r <= valid_p_r;
            last_s_r  <= last_p_r;
            sat_s_r   <= sat_p_r;
        end
    end

    // Accumulate step: the first beat of a vector starts from zero with a clean overflow flag.
    always_comb begin
        base_s     = '0;
        ovf_step_s = 1'b0;
        sum_ext_s  = ACC_W'($signed(sum_r));
        if (first_r) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        step_s  = sat_add(64'($signed(base_s)), 64'($signed(sum_ext_s)), sat_s_r, ACC_W);
        value_s = step_s.value[ACC_W-1:0];
        if (first_r) begin
            ovf_step_s = step_s.ovf;
        end else begin
            ovf_step_s = ovf_acc_r | step_s.ovf;
        end
    end

    // Bits above ACC_W in the helper's container carry nothing for this instance.
    assign unused_hi_s = ^step_s.value[63:ACC_W];

    // Stage A register: accumulator, vector-start flag and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r     <= '0;
            first_r   <= 1'b1;
            ovf_acc_r <= 1'b0;
            o_res     <= '0;
            o_ovf     <= 1'b0;
            o_valid   <= 1'b0;
        end else if (en_s) begin
            if (valid_s_r) begin
                if (last_s_r) begin
                    o_res     <= value_s;
                    o_ovf     <= ovf_step_s;
                    o_valid   <= 1'b1;
                    first_r   <= 1'b1;
                    ovf_acc_r <= ovf_step_s;
                end else begin
                    acc_r     <= value_s;
                    ovf_acc_r <= ovf_step_s;
                    first_r   <= 1'b0;
                    o_valid   <= 1'b0;
                end
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
